// File: rtl/signed_mac_ctrl_pkg.sv
// Shared definitions for the signed multiply-accumulate controller:
// FSM encoding, multiplier latency limits and the saturating product counter.
package signed_mac_ctrl_pkg;

    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 8;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } mac_state_e;

    // Sideband that travels alongside a product while the multiplier works on it.
    typedef struct packed {
        logic sign;
        logic last;
    } mac_tag_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == '1) ? value : value + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/signed_mac_ctrl_if.sv
// Operand stream, external multiplier port and result stream of signed_mac_ctrl.
// The controller takes the slave view; the environment drives the master view.
interface signed_mac_ctrl_if #(
    parameter int BW    = 8,
    parameter int ACC_W = 24
);
    logic              in_valid;
    logic              in_ready;
    logic [BW-1:0]     in_a;
    logic [BW-1:0]     in_b;
    logic              in_last;

    logic              mul_valid;
    logic [BW-1:0]     mul_a;
    logic [BW-1:0]     mul_b;
    logic [2*BW-1:0]   mul_p;

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [7:0]        out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_p, out_ready,
        output in_ready, mul_valid, mul_a, mul_b, out_valid, out_sum, out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_last, mul_p, out_ready,
        input  in_ready, mul_valid, mul_a, mul_b, out_valid, out_sum, out_count
    );

endinterface

// File: rtl/signed_mac_ctrl_sign_mag_split.sv
// Splits a two's-complement value into its sign bit and unsigned magnitude;
// the most negative value maps to 2^(W-1), which still fits in W unsigned bits.
module sign_mag_split #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] mag,
    output logic         sign
);

    assign sign = value[W-1];
    assign mag  = sign ? (~value + W'(1)) : value;

endmodule

// File: rtl/signed_mac_ctrl.sv
// Signed dot-product controller around an external unsigned multiplier:
// magnitudes go out, signs ride a matching delay line and are reapplied on return.
module signed_mac_ctrl
    import signed_mac_ctrl_pkg::*;
#(
    parameter int BW      = 8,
    parameter int MUL_LAT = 2,
    parameter int ACC_W   = 24
) (
    input logic              clk,
    input logic              rst,
    signed_mac_ctrl_if.slave bus
);

    if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_mul_lat
        $error("signed_mac_ctrl: MUL_LAT %0d outside %0d..%0d", MUL_LAT, MUL_LAT_MIN, MUL_LAT_MAX);
    end
    if (ACC_W < 2 * BW + 1) begin : g_bad_acc_w
        $error("signed_mac_ctrl: ACC_W %0d must be at least 2*BW+1", ACC_W);
    end

    mac_state_e         state_q, state_d;
    logic               accum_state, hold_state;
    logic               load_result, clear_acc;
    logic               issue;

    logic [BW-1:0]      mag_a, mag_b;
    logic               sign_a, sign_b;

    logic [MUL_LAT-1:0] pipe_valid_q;
    mac_tag_t           pipe_tag_q [MUL_LAT];
    logic               exit_valid;
    mac_tag_t           exit_tag;

    logic [ACC_W-1:0]   prod_ext, addend;
    logic [ACC_W-1:0]   acc_q, acc_next;
    logic [COUNT_W-1:0] count_q, count_next;
    logic [ACC_W-1:0]   out_sum_q;
    logic [COUNT_W-1:0] out_count_q;

    sign_mag_split #(.W(BW)) u_split_a (
        .value (bus.in_a),
        .mag   (mag_a),
        .sign  (sign_a)
    );

    sign_mag_split #(.W(BW)) u_split_b (
        .value (bus.in_b),
        .mag   (mag_b),
        .sign  (sign_b)
    );

    // Ready is a function of state alone; rst only forces it low while held.
    assign bus.in_ready  = accum_state && !rst;
    assign issue         = bus.in_valid && bus.in_ready;
    assign bus.mul_valid = issue;
    assign bus.mul_a     = issue ? mag_a : '0;
    assign bus.mul_b     = issue ? mag_b : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        accum_state = 1'b0;
        hold_state  = 1'b0;
        load_result = 1'b0;
        clear_acc   = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                accum_state = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (exit_valid && exit_tag.last) begin
                    load_result = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                hold_state = 1'b1;
                if (bus.out_ready) begin
                    clear_acc = 1'b1;
                    state_d   = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Valid bits decide what the accumulator consumes, so they must clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
        end else begin
            pipe_valid_q[0] <= issue;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
        end
    end

    // NOTE: the tag delay line has no reset; its contents are only looked at
    // when the matching valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        pipe_tag_q[0] <= '{sign: sign_a ^ sign_b, last: bus.in_last};
        for (int i = 1; i < MUL_LAT; i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
        end
    end

    assign exit_valid = pipe_valid_q[MUL_LAT-1];
    assign exit_tag   = pipe_tag_q[MUL_LAT-1];

    // A zero product stays zero when negated, so no special case is needed.
    assign prod_ext   = ACC_W'(bus.mul_p);
    assign addend     = exit_tag.sign ? (~prod_ext + ACC_W'(1)) : prod_ext;
    assign acc_next   = acc_q + addend;
    assign count_next = sat_inc(count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else if (clear_acc) begin
            acc_q   <= '0;
            count_q <= '0;
        end else if (exit_valid) begin
            acc_q   <= acc_next;
            count_q <= count_next;
            if (load_result) begin
                out_sum_q   <= acc_next;
                out_count_q <= count_next;
            end
        end
    end

    assign bus.out_valid = hold_state && !rst;
    assign bus.out_sum   = rst ? '0 : out_sum_q;
    assign bus.out_count = rst ? '0 : out_count_q;

endmodule

// File: doc/signed_mac_ctrl.md
SIGNED_MAC_CTRL -- requirements
Module: signed_mac_ctrl

Interface
REQ-001 SHALL have parameter BW, default 8: signed operand width in bits.
REQ-002 SHALL have parameter MUL_LAT, default 2: fixed latency of the external unsigned multiplier in cycles; legal range 1..8.
REQ-003 SHALL have parameter ACC_W, default 24: signed accumulator and result width; ACC_W >= 2*BW+1.
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  operand pair and in_last are valid.
REQ-007 in_ready  out  1  the block accepts the operand pair this cycle.
REQ-008 in_a, in_b  in  BW each  two's-complement operands.
REQ-009 in_last  in  1  marks the final pair of a dot product.
REQ-010 mul_valid  out  1  issue strobe to the external multiplier.
REQ-011 mul_a, mul_b  out  BW each  unsigned magnitudes sent to the multiplier.
REQ-012 mul_p  in  2*BW  unsigned product, valid exactly MUL_LAT cycles after its mul_valid.
REQ-013 out_valid  out  1  the dot-product result is valid.
REQ-014 out_ready  in  1  the downstream consumer accepts the result.
REQ-015 out_sum  out  ACC_W  signed dot-product result.
REQ-016 out_count  out  8  number of products in the result; saturates at 255.

Function
REQ-017 An input handshake SHALL complete in a cycle with in_valid=1 and in_ready=1; the block SHALL issue mul_valid=1 in that same cycle.
REQ-018 mul_a and mul_b SHALL be |in_a| and |in_b| as BW-bit unsigned values; -2^(BW-1) SHALL map to 2^(BW-1).
REQ-019 The block SHALL carry sign = a_msb XOR b_msb, in_last and a valid bit through a MUL_LAT-deep shift pipeline aligned with mul_p.
REQ-020 At pipeline exit the product SHALL be zero-extended to ACC_W bits, negated (two's complement) when sign=1, and added to the accumulator.
REQ-021 Accumulation SHALL wrap modulo 2^ACC_W; no saturation and no overflow flag.
REQ-022 FSM states SHALL be ACCUM, DRAIN and HOLD.
  - ACCUM: in_ready=1; accepting a pair with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0; when the last-marked product exits the pipeline, out_sum takes the final sum, out_valid is asserted and the state moves to HOLD.
  - HOLD: out_valid=1 and in_ready=0; when out_ready=1, the state moves to ACCUM and the accumulator and count clear to 0 in that cycle.
REQ-023 out_sum and out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 End-to-end latency from the last accepted pair to out_valid SHALL be MUL_LAT+1 cycles.
REQ-025 A last-marked pair accepted with no earlier pairs SHALL produce a result of that single product with count 1.
REQ-026 Zero operands SHALL flow normally; a zero product with sign=1 SHALL add 0.
REQ-027 out_valid SHALL NOT depend combinationally on out_ready; in_ready SHALL depend only on the FSM state.

Reset
REQ-028 While rst=1 the block SHALL go to ACCUM.
REQ-029 While rst=1 the accumulator, count and all pipeline valid bits SHALL clear to 0.
REQ-030 While rst=1 the outputs SHALL read out_valid=0, mul_valid=0, out_sum=0, out_count=0, mul_a=0 and mul_b=0; in_ready SHALL read 0.
REQ-031 After rst is released, in_ready SHALL be 1 in the first cycle.
REQ-032 Products in flight when reset is asserted mid-operation SHALL be discarded; mul_p SHALL be ignored until a new mul_valid has propagated.

Structure
REQ-033 The state encoding and the MUL_LAT range limits SHALL live in the shared accelerator package.
REQ-034 The abs/sign split SHALL be one sub-module, sign_mag_split, instantiated once per operand; it outputs the magnitude and the sign bit.
REQ-035 The multiplier is external; this block SHALL contain no multiplier.

Verification (BW=8, MUL_LAT=2, ACC_W=24)
REQ-036 Single pair (3, -4, last) -> mul_a=3, mul_b=4; out_valid 3 cycles after acceptance; out_sum=-12, out_count=1.
REQ-037 Pairs (-128,-128), (-128,127), (5,5, last) -> out_sum=16384-16256+25=153, out_count=3.
REQ-038 Back-to-back pairs without gaps, then out_ready held 0 for 5 cycles -> in_ready=0 and out_sum stable throughout; the accumulator clears on the accepting cycle.
REQ-039 600 pairs (127,127) -> out_sum=600*16129 mod 2^24 wraps as specified; out_count=255.
REQ-040 rst pulsed one cycle while 2 products are in flight -> no out_valid afterwards; the next single pair (2,2, last) -> out_sum=4.
REQ-041 Pair (0,-7, last) -> out_sum=0; a random reference model over 10k pairs SHALL match.
